// File: rtl/core_if_fetch_pkg.sv
// Shared defines, entry type and helpers for the instruction-fetch stage.
// Optional misaligned-target checking is enabled by defining CORE_IF_MISALIGN_CHK_EN.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif
`ifndef CORE_RESET_PC
`define CORE_RESET_PC 32'h8000_0000
`endif
`ifndef CORE_IF_QUEUE_DEPTH
`define CORE_IF_QUEUE_DEPTH 2
`endif

package core_if_fetch_pkg;
  localparam int XLEN = `CORE_XLEN;
  localparam int ILEN = `CORE_INST_WIDTH;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            err;
`ifdef CORE_IF_MISALIGN_CHK_EN
    logic            misalign;
`endif
    logic            filled;
  } if_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction
endpackage

// File: rtl/core_if_fetch_queue.sv
// In-order fetch queue: entries are reserved at request issue, filled by
// responses in order, and popped by ID. A flush clears every pointer.
module core_if_fetch_queue
  import core_if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_inst,
  input  logic            fill_err,
  input  logic            pop,
`ifdef CORE_IF_MISALIGN_CHK_EN
  input  logic            push_mis,
  input  logic [XLEN-1:0] mis_pc,
`endif
  output logic [PW:0]     cnt,
  output logic [PW:0]     unfilled,
  output if_entry_t       head
);

  if_entry_t   entries [DEPTH];
  if_entry_t   alloc_entry;
  logic [PW:0] alloc_ptr;
  logic [PW:0] fill_ptr;
  logic [PW:0] head_ptr;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign cnt      = alloc_ptr - head_ptr;
  assign unfilled = alloc_ptr - fill_ptr;
  assign head     = entries[head_ptr[PW-1:0]];

  always_comb begin
    alloc_entry    = '0;
    alloc_entry.pc = alloc_pc;
  end

`ifdef CORE_IF_MISALIGN_CHK_EN
  if_entry_t mis_entry;
  always_comb begin
    mis_entry          = '0;
    mis_entry.pc       = mis_pc;
    mis_entry.misalign = 1'b1;
    mis_entry.filled   = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (clear) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
`ifdef CORE_IF_MISALIGN_CHK_EN
      if (push_mis) begin
        entries[0] <= mis_entry;
        alloc_ptr  <= {{PW{1'b0}}, 1'b1};
        fill_ptr   <= {{PW{1'b0}}, 1'b1};
      end
`endif
    end else begin
      if (alloc) begin
        entries[alloc_ptr[PW-1:0]] <= alloc_entry;
        alloc_ptr <= alloc_ptr + {{PW{1'b0}}, 1'b1};
      end
      if (fill) begin
        entries[fill_ptr[PW-1:0]].inst   <= fill_inst;
        entries[fill_ptr[PW-1:0]].err    <= fill_err;
        entries[fill_ptr[PW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + {{PW{1'b0}}, 1'b1};
      end
      if (pop) begin
        head_ptr <= head_ptr + {{PW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/core_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches, discards stale
// responses after a redirect. Misaligned-target trap entries: CORE_IF_MISALIGN_CHK_EN.
module core_if_fetch
  import core_if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = `CORE_RESET_PC,
  parameter int              QUEUE_DEPTH = `CORE_IF_QUEUE_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic            o_ifu_req_valid,
  input  logic            i_ifu_req_ready,
  output logic [XLEN-1:0] o_ifu_req_addr,
  input  logic            i_ifu_rsp_valid,
  input  logic [ILEN-1:0] i_ifu_rsp_inst,
  input  logic            i_ifu_rsp_err,
  output logic            o_ifu_rsp_ready,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [ILEN-1:0] o_id_inst,
  output logic [XLEN-1:0] o_id_pc,
`ifdef CORE_IF_MISALIGN_CHK_EN
  output logic            o_id_misalign,
`endif
  output logic            o_id_bus_err
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(QUEUE_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next;
  logic [PW:0]     drop_cnt;
  logic [PW:0]     drop_next;
  logic [PW:0]     drop_flush;
  logic [PW+1:0]   drop_sum;
  logic [PW:0]     cnt;
  logic [PW:0]     unfilled;
  if_entry_t       head;
  logic            req_hs;
  logic            fill;
  logic            pop;
  logic            stall;

`ifdef CORE_IF_MISALIGN_CHK_EN
  logic stall_r;
  logic mis_flush;
  assign mis_flush = i_flush && (i_flush_pc[1:0] != 2'b00);
  assign stall     = stall_r;

  // A misaligned redirect parks fetch until the next flush.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_r <= 1'b0;
    else if (i_flush) stall_r <= mis_flush;
  end
  assign o_id_misalign = head.misalign;
`else
  assign stall = 1'b0;
`endif

  assign o_ifu_req_valid = !i_rst && !i_flush && (cnt < DEPTH_C) && !stall;
  assign o_ifu_req_addr  = pc_r;
  assign o_ifu_rsp_ready = 1'b1;
  assign req_hs          = o_ifu_req_valid && i_ifu_req_ready;
  assign fill            = i_ifu_rsp_valid && !i_flush && (drop_cnt == '0);
  assign o_id_valid      = head.filled && (cnt != '0) && !i_flush;
  assign pop             = o_id_valid && i_id_ready;
  assign o_id_inst       = head.inst;
  assign o_id_pc         = head.pc;
  assign o_id_bus_err    = head.err;

  // A response in the flush cycle retires either a pending drop or the oldest
  // unfilled entry; both are already in drop_cnt + unfilled, so always subtract it.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + {1'b0, unfilled} - {{(PW+1){1'b0}}, i_ifu_rsp_valid};
    if (drop_sum > {1'b0, DEPTH_C}) drop_flush = DEPTH_C;
    else drop_flush = drop_sum[PW:0];
    if (i_flush) drop_next = drop_flush;
    else if (i_ifu_rsp_valid && (drop_cnt != '0)) drop_next = drop_cnt - {{PW{1'b0}}, 1'b1};
    else drop_next = drop_cnt;
  end

  always_comb begin
    if (i_flush) pc_next = word_align(i_flush_pc);
    else if (req_hs) pc_next = pc_r + PC_STEP;
    else pc_next = pc_r;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_r     <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      pc_r     <= pc_next;
      drop_cnt <= drop_next;
    end
  end

  core_if_fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (i_clk),
    .rst       (i_rst),
    .clear     (i_flush),
    .alloc     (req_hs),
    .alloc_pc  (pc_r),
    .fill      (fill),
    .fill_inst (i_ifu_rsp_inst),
    .fill_err  (i_ifu_rsp_err),
    .pop       (pop),
`ifdef CORE_IF_MISALIGN_CHK_EN
    .push_mis  (mis_flush),
    .mis_pc    (i_flush_pc),
`endif
    .cnt       (cnt),
    .unfilled  (unfilled),
    .head      (head)
  );

endmodule

// File: tb/tb_core_if_fetch.sv
// Directed bench for core_if_fetch: in-order memory model, request/ID scoreboard,
// flush/drop, held-request redirect, bus error and asynchronous reset.
module tb_core_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_inst = 32'h0;
  logic        rsp_err = 1'b0;
  logic        rsp_ready;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_bus_err;
`ifdef CORE_IF_MISALIGN_CHK_EN
  logic        id_misalign;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_issue = 0;
  int          n_pop = 0;
  int          n_err = 0;
  logic [31:0] exp_addr = 32'h8000_0000;
  logic [31:0] exp_next_pc = 32'h8000_0000;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          mem_en = 1'b1;
  logic [31:0] mq [$];

  always #5 clk = ~clk;

  core_if_fetch dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .i_flush_pc      (flush_pc),
    .o_ifu_req_valid (req_valid),
    .i_ifu_req_ready (req_ready),
    .o_ifu_req_addr  (req_addr),
    .i_ifu_rsp_valid (rsp_valid),
    .i_ifu_rsp_inst  (rsp_inst),
    .i_ifu_rsp_err   (rsp_err),
    .o_ifu_rsp_ready (rsp_ready),
    .o_id_valid      (id_valid),
    .i_id_ready      (id_ready),
    .o_id_inst       (id_inst),
    .o_id_pc         (id_pc),
`ifdef CORE_IF_MISALIGN_CHK_EN
    .o_id_misalign   (id_misalign),
`endif
    .o_id_bus_err    (id_bus_err)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: memory answers the oldest accepted request, handshakes are scored.
  task automatic tick();
    logic [31:0] ra;
    #1;
    if (mem_en && mq.size() > 0) begin
      ra = mq.pop_front();
      rsp_valid = 1'b1;
      rsp_inst  = inst_of(ra);
      rsp_err   = (ra == err_addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_inst  = 32'h0;
      rsp_err   = 1'b0;
    end
    #1;
    if (req_valid && req_ready) begin
      check32("req_addr", req_addr, exp_addr);
      mq.push_back(req_addr);
      exp_addr = exp_addr + 32'd4;
      n_issue++;
    end
    if (id_valid && id_ready) begin
      check32("id_pc", id_pc, exp_next_pc);
      check32("id_inst", id_inst, inst_of(exp_next_pc));
      check1("id_bus_err", id_bus_err, exp_next_pc == err_addr);
      if (id_bus_err) n_err++;
      exp_next_pc = exp_next_pc + 32'd4;
      n_pop++;
    end
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] target);
    flush       = 1'b1;
    flush_pc    = target;
    exp_addr    = target & 32'hFFFF_FFFC;
    exp_next_pc = target;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst_req_valid", req_valid, 1'b0);
    check32("rst_req_addr", req_addr, 32'h8000_0000);
    check1("rst_rsp_ready", rsp_ready, 1'b1);
    check1("rst_id_valid", id_valid, 1'b0);
    check32("rst_id_pc", id_pc, 32'h0);
    check32("rst_id_inst", id_inst, 32'h0);
    check1("rst_id_bus_err", id_bus_err, 1'b0);

    // 1: sequential fetch after reset release
    req_ready = 1'b1;
    id_ready  = 1'b1;
    rst = 1'b0;
    #1;
    check1("t1_first_req", req_valid, 1'b1);
    check32("t1_first_addr", req_addr, 32'h8000_0000);
    repeat (12) tick();
    check1("t1_pops", n_pop >= 4, 1'b1);

    // 2: ID stalled -> exactly QUEUE_DEPTH issues, then in-order drain
    id_ready = 1'b0;
    do_flush(32'h0000_2000);
    n_issue = 0;
    repeat (5) tick();
    check32("t2_issue", 32'(n_issue), 32'd2);
    check1("t2_req_valid", req_valid, 1'b0);
    check1("t2_id_valid", id_valid, 1'b1);
    check32("t2_id_pc", id_pc, 32'h0000_2000);
    check32("t2_id_inst", id_inst, inst_of(32'h0000_2000));
    id_ready = 1'b1;
    n_pop = 0;
    repeat (6) tick();
    check1("t2_drain", n_pop >= 2, 1'b1);

    // 3: two requests in flight, flush drops both late responses
    mem_en = 1'b0;
    repeat (4) tick();
    check1("t3_full", req_valid, 1'b0);
    check1("t3_no_id", id_valid, 1'b0);
    do_flush(32'h0000_1000);
    mem_en = 1'b1;
    id_ready = 1'b0;
    repeat (3) tick();
    check1("t3_id_valid", id_valid, 1'b1);
    check32("t3_id_pc", id_pc, 32'h0000_1000);
    check32("t3_id_inst", id_inst, inst_of(32'h0000_1000));
    id_ready = 1'b1;
    n_pop = 0;
    repeat (4) tick();
    check1("t3_pops", n_pop >= 1, 1'b1);

    // 4: held request retracted by a flush
    req_ready = 1'b0;
    repeat (4) tick();
    check1("t4_held_valid", req_valid, 1'b1);
    check32("t4_held_addr", req_addr, exp_addr);
    tick();
    check1("t4_held_valid2", req_valid, 1'b1);
    check32("t4_held_addr2", req_addr, exp_addr);
    flush = 1'b1;
    flush_pc = 32'h0000_3000;
    #1;
    check1("t4_flush_req", req_valid, 1'b0);
    check1("t4_flush_id", id_valid, 1'b0);
    exp_addr = 32'h0000_3000;
    exp_next_pc = 32'h0000_3000;
    tick();
    flush = 1'b0;
    #1;
    check1("t4_new_valid", req_valid, 1'b1);
    check32("t4_new_addr", req_addr, 32'h0000_3000);
    req_ready = 1'b1;
    n_issue = 0;
    repeat (3) tick();
    check1("t4_issue", n_issue >= 1, 1'b1);

`ifdef CORE_IF_MISALIGN_CHK_EN
    // 6: misaligned redirect pushes a trap entry and stalls fetch
    req_ready = 1'b0;
    repeat (5) tick();
    id_ready = 1'b0;
    req_ready = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h0000_1002;
    #1;
    check1("t6_flush_req", req_valid, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    check1("t6_no_req", req_valid, 1'b0);
    check1("t6_id_valid", id_valid, 1'b1);
    check32("t6_id_pc", id_pc, 32'h0000_1002);
    check32("t6_id_inst", id_inst, 32'h0);
    check1("t6_misalign", id_misalign, 1'b1);
    repeat (3) tick();
    check1("t6_stalled", req_valid, 1'b0);
    do_flush(32'h0000_4000);
    #1;
    check1("t6_resume", req_valid, 1'b1);
    check32("t6_resume_addr", req_addr, 32'h0000_4000);
`endif

    // 5: bus error flagged only on the fetch of 8000_0004
    id_ready = 1'b1;
    req_ready = 1'b1;
    err_addr = 32'h8000_0004;
    do_flush(32'h8000_0000);
    n_err = 0;
    n_pop = 0;
    repeat (12) tick();
    check32("t5_err_count", 32'(n_err), 32'd1);
    check1("t5_pops", n_pop >= 3, 1'b1);

    // Asynchronous reset in the middle of traffic
    rst = 1'b1;
    #1;
    check1("mrst_req_valid", req_valid, 1'b0);
    check32("mrst_req_addr", req_addr, 32'h8000_0000);
    check1("mrst_id_valid", id_valid, 1'b0);
    check32("mrst_id_pc", id_pc, 32'h0);
    check1("mrst_id_bus_err", id_bus_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
